// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB for each
// instruction, handshakes with stallable instruction/data memories, and
// bounds every memory stall with a timeout that parks the FSM in HALT.
//
// Handshake: imem_req/dmem_req stay high for every cycle spent waiting in
// FETCH/MEM; a transfer completes in the cycle where req and ready are both
// high. A ready seen in any other state is ignored.
module multicycle_control #(
  parameter int OPW     = 6,
  parameter int ALUW    = 5,
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            cmp_le,
  output logic            imem_req,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            alu_src,
  output logic [ALUW-1:0] alu_ctrl,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            link,
  output logic [1:0]      fault,
  output logic [2:0]      dbg_state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [OPW-1:0] OP_ANDR = OPW'(6'b100000);
  localparam logic [OPW-1:0] OP_NORR = OPW'(6'b100110);
  localparam logic [OPW-1:0] OP_NOTR = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ROLV = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_RORV = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_NORI = OPW'(6'b001110);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BLEU = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_JR   = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b000011);

  // Last cycle on which a stalled memory may still answer.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  logic [2:0]      state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [ALUW-1:0] alu_q, alu_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]      fault_q, fault_d;

  logic is_rtype, is_nori, is_lw, is_sw, is_bleu, is_jr, is_jal, is_known;

  // Only the opcode and ALU fields of the instruction word matter here.
  logic unused_instr;
  assign unused_instr = ^instr;

  assign is_rtype = (op_q == OP_ANDR) || (op_q == OP_NORR) || (op_q == OP_NOTR) ||
                    (op_q == OP_ROLV) || (op_q == OP_RORV);
  assign is_nori  = (op_q == OP_NORI);
  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_bleu  = (op_q == OP_BLEU);
  assign is_jr    = (op_q == OP_JR);
  assign is_jal   = (op_q == OP_JAL);
  assign is_known = is_rtype || is_nori || is_lw || is_sw || is_bleu || is_jr || is_jal;

  // Next-state, IR capture, stall timeout and sticky fault.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    alu_d   = alu_q;
    tmo_d   = '0;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          op_d    = instr[31:32-OPW];
          alu_d   = instr[31:32-ALUW];
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          fault_d = 2'd2;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        if (is_known) begin
          state_d = S_EXEC;
        end else begin
          fault_d = 2'd1;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        if (is_rtype || is_nori)  state_d = S_WB;
        else if (is_lw || is_sw)  state_d = S_MEM;
        else                      state_d = S_FETCH;
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = is_sw ? S_FETCH : S_WB;
        end else if (tmo_q == TMO_LAST) begin
          fault_d = 2'd3;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      alu_q   <= '0;
      tmo_q   <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

  // Control outputs; reset forces reset values in the same cycle.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src    = 1'b0;
    alu_ctrl   = '0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    link       = 1'b0;
    fault      = 2'd0;
    if (reset) begin
      imem_req = 1'b1;
    end else begin
      alu_ctrl = alu_q;
      fault    = fault_q;
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        S_EXEC: begin
          alu_src = is_nori || is_lw || is_sw;
          if (is_bleu) begin
            pc_write = cmp_le;
            pc_src   = 2'd1;
          end else if (is_jr) begin
            pc_write = 1'b1;
            pc_src   = 2'd3;
          end else if (is_jal) begin
            pc_write  = 1'b1;
            pc_src    = 2'd2;
            reg_write = 1'b1;
            link      = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_sw;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype;
          mem_to_reg = is_lw;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction streams with random
// memory stalls, timeouts, illegal opcodes and mid-instruction resets.
module tb_multicycle_control;

  localparam int TMO_MAX = 15;

  localparam int C_R = 0, C_NORI = 1, C_LW = 2, C_SW = 3, C_BLEU = 4,
                 C_JR = 5, C_JAL = 6, C_BAD = 7;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src;
    logic [4:0] alu_ctrl;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic [1:0] fault;
  } obs_t;

  localparam int W = 16 + $bits(obs_t);

  // clock / reset / DUT
  logic        clk = 1'b0;
  logic        reset, imem_ready, dmem_ready, cmp_le;
  logic [31:0] instr;
  logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, alu_src;
  logic        reg_dst, mem_to_reg, reg_write, link;
  logic [1:0]  pc_src, fault;
  logic [4:0]  alu_ctrl;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_control dut (
    .clk(clk), .reset(reset), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .cmp_le(cmp_le), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
    .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .link(link), .fault(fault), .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic [1:0] mon_prev_fault = 2'd0;

  // reference model state: what the datapath-visible IR and fault hold
  logic [4:0] m_alu = 5'd0;
  logic [1:0] m_fault = 2'd0;
  logic [1:0] m_prev_fault = 2'd0;

  logic [5:0] legal_ops[11] = '{6'b100000, 6'b100110, 6'b000100, 6'b000000,
                                6'b000010, 6'b001110, 6'b100011, 6'b101011,
                                6'b010000, 6'b001000, 6'b000011};
  logic [5:0] bad_ops[4] = '{6'b111111, 6'b000001, 6'b010101, 6'b110000};

  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'b100000, 6'b100110, 6'b000100, 6'b000000, 6'b000010: return C_R;
      6'b001110: return C_NORI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b010000: return C_BLEU;
      6'b001000: return C_JR;
      6'b000011: return C_JAL;
      default:   return C_BAD;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Outputs expected in a cycle where nothing is strobed.
  function automatic obs_t base();
    obs_t o;
    o = '0;
    o.alu_ctrl = m_alu;
    o.fault    = m_fault;
    return o;
  endfunction

  // monitor: compares whenever the DUT strobes, requests or changes fault
  always @(negedge clk) begin
    obs_t a;
    logic [W-1:0] got, e;
    logic trig;
    a = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_src,
         alu_ctrl, reg_dst, mem_to_reg, reg_write, link, fault};
    trig = imem_req | dmem_req | ir_write | pc_write | reg_write | link |
           alu_src | (fault != mon_prev_fault);
    mon_prev_fault = fault;
    if (mon_en && trig) begin
      got = {cyc[15:0], a};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d state=%0d got=%h required=none", cyc, dbg_state, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL event cyc=%0d state=%0d got=%h required=%h", cyc, dbg_state, got, e);
        end
      end
    end
  end

  // driver: one clock cycle of inputs plus the outputs expected in it
  task automatic tick(input logic rst, input logic imr, input logic dmr,
                      input logic cle, input logic [31:0] ins, input obs_t o);
    @(posedge clk);
    #1;
    reset = rst; imem_ready = imr; dmem_ready = dmr; cmp_le = cle; instr = ins;
    if (o.imem_req | o.dmem_req | o.ir_write | o.pc_write | o.reg_write |
        o.link | o.alu_src | (o.fault != m_prev_fault))
      exp_q.push_back({cyc[15:0], o});
    m_prev_fault = o.fault;
  endtask

  task automatic do_reset(input int n);
    obs_t o;
    m_alu = 5'd0;
    m_fault = 2'd0;
    for (int i = 0; i < n; i++) begin
      o = base();
      o.imem_req = 1'b1;
      tick(1'b1, rb(), rb(), rb(), $urandom, o);
    end
  endtask

  // HALT: nothing strobed for 20 cycles, fault held, then reset.
  task automatic halt_fault(input logic [1:0] f);
    m_fault = f;
    for (int i = 0; i < 20; i++) tick(1'b0, rb(), rb(), rb(), $urandom, base());
    do_reset(2);
  endtask

  // One instruction: iw/dw = cycles the memory holds ready low.
  task automatic run_instr(input logic [5:0] op, input int iw, input int dw,
                           input logic cle, input logic abort_mem);
    obs_t o;
    logic [31:0] ins;
    logic got;
    int c;
    ins = {op, 26'($urandom)};
    c = op_class(op);
    got = 1'b0;
    for (int k = 0; k < TMO_MAX; k++) begin
      o = base();
      o.imem_req = 1'b1;
      if (k == iw) begin
        o.ir_write = 1'b1;
        o.pc_write = 1'b1;
        tick(1'b0, 1'b1, rb(), rb(), ins, o);
        got = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, rb(), rb(), $urandom, o);
    end
    if (!got) begin halt_fault(2'd2); return; end
    m_alu = ins[31:27];
    tick(1'b0, rb(), rb(), rb(), $urandom, base());          // decode
    if (c == C_BAD) begin halt_fault(2'd1); return; end
    o = base();                                               // execute
    o.alu_src = (c == C_NORI) || (c == C_LW) || (c == C_SW);
    if (c == C_BLEU) begin o.pc_write = cle;  o.pc_src = 2'd1; end
    if (c == C_JR)   begin o.pc_write = 1'b1; o.pc_src = 2'd3; end
    if (c == C_JAL)  begin
      o.pc_write = 1'b1; o.pc_src = 2'd2; o.reg_write = 1'b1; o.link = 1'b1;
    end
    tick(1'b0, rb(), rb(), (c == C_BLEU) ? cle : rb(), $urandom, o);
    if (c == C_BLEU || c == C_JR || c == C_JAL) return;
    if (c == C_LW || c == C_SW) begin
      if (abort_mem) begin
        m_alu = 5'd0;
        m_fault = 2'd0;
        o = base();
        o.imem_req = 1'b1;
        tick(1'b1, rb(), 1'b0, rb(), $urandom, o);
        return;
      end
      got = 1'b0;
      for (int k = 0; k < TMO_MAX; k++) begin
        o = base();
        o.dmem_req = 1'b1;
        o.dmem_we  = (c == C_SW);
        tick(1'b0, rb(), (k == dw), rb(), $urandom, o);
        if (k == dw) begin got = 1'b1; break; end
      end
      if (!got) begin halt_fault(2'd3); return; end
      if (c == C_SW) return;
    end
    o = base();                                               // writeback
    o.reg_write  = 1'b1;
    o.reg_dst    = (c == C_R);
    o.mem_to_reg = (c == C_LW);
    tick(1'b0, rb(), rb(), rb(), $urandom, o);
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 19);
    return (r < 16) ? (r % 3) : (12 + (r - 16));
  endfunction

  initial begin
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; cmp_le = 1'b0; instr = '0;
    mon_en = 1'b1;
    do_reset(2);
    // directed scenarios
    run_instr(6'b100000, 0, 0, 1'b0, 1'b0);   // andr, zero wait
    run_instr(6'b100011, 0, 3, 1'b0, 1'b0);   // lw, dmem stalls 3 cycles
    run_instr(6'b010000, 0, 0, 1'b1, 1'b0);   // bleu taken
    run_instr(6'b010000, 0, 0, 1'b0, 1'b0);   // bleu not taken
    run_instr(6'b001000, 1, 0, 1'b0, 1'b0);   // jr
    run_instr(6'b000011, 2, 0, 1'b0, 1'b0);   // jal
    run_instr(6'b001110, 0, 0, 1'b0, 1'b0);   // nori
    run_instr(6'b111111, 0, 0, 1'b0, 1'b0);   // illegal -> fault 1
    run_instr(6'b100000, 15, 0, 1'b0, 1'b0);  // imem timeout -> fault 2
    run_instr(6'b100110, 14, 0, 1'b0, 1'b0);  // ready on last cycle wins
    run_instr(6'b101011, 0, 0, 1'b0, 1'b1);   // reset during sw MEM
    run_instr(6'b101011, 0, 2, 1'b0, 1'b0);   // sw after abort
    run_instr(6'b100011, 0, 15, 1'b0, 1'b0);  // dmem timeout -> fault 3
    run_instr(6'b100011, 0, 14, 1'b0, 1'b0);  // dmem ready on last cycle
    // randomized stream
    for (int i = 0; i < 250; i++) begin
      logic [5:0] op;
      int c;
      if ($urandom_range(0, 99) < 4) op = bad_ops[$urandom_range(0, 3)];
      else                           op = legal_ops[$urandom_range(0, 10)];
      c = op_class(op);
      run_instr(op, rand_wait(), rand_wait(), rb(),
                ((c == C_LW) || (c == C_SW)) && ($urandom_range(0, 99) < 5));
    end
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
